alu_issue: RTL
==============

Name: alu_issue

Overview:
Decode-and-issue stage that drives the 32-bit RV32I ALU's operand and control interface. It accepts one instruction plus its register operands per handshake and decodes OP, OP-IMM, LUI and AUIPC. It selects operands a/b, generates operation (funct3), control (sub/sra) and the lt/ltu flags, and presents them registered to the execute stage over a valid/ready handshake. It sits between register-file read and the ALU.

Parameters:
SKID_BUFFER, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single pipeline register with in_ready = !out_valid || out_ready
ENABLE_UPPER, 1, 1 = LUI/AUIPC decoded; 0 = treated as illegal

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held entries
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept
instr  input  32  raw instruction word
pc  input  32  instruction address (AUIPC operand)
rs1_data  input  32  register rs1 value
rs2_data  input  32  register rs2 value
out_valid  output  1  issued bundle valid
out_ready  input  1  execute stage accepts
alu_a  output  32  ALU operand a
alu_b  output  32  ALU operand b
alu_operation  output  3  ALU function select (funct3 encoding)
alu_control  output  1  0 = add/srl, 1 = sub/sra
alu_lt  output  1  signed alu_a < alu_b
alu_ltu  output  1  unsigned alu_a < alu_b
rd  output  5  destination register
illegal  output  1  instruction not decodable by this stage

Behaviour:
- Reset (async, rst_n=0): out_valid=0, all data outputs=0, skid entry empty, in_ready=1 after reset release.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready. Latency 1 cycle from input transfer to out_valid.
- SKID_BUFFER=1: in_ready registered = skid entry empty. Input arriving while the output is held and not taken goes to the skid entry. When the output is taken, the skid entry moves to the output. Full throughput, no bubble under continuous out_ready.
- SKID_BUFFER=0: in_ready = !out_valid || out_ready (combinational).
- Output bundle held stable while out_valid && !out_ready.
- flush: next edge sets out_valid=0 and empties the skid entry. A concurrent input transfer is dropped. Flush beats simultaneous in/out transfers.
- OP (0110011): a=rs1_data, b=rs2_data, operation=funct3, control=instr[30]. funct7 must be 0000000, or 0100000 only for funct3 000/101. Otherwise illegal.
- OP-IMM (0010011): a=rs1_data, b=sign-extended instr[31:20]. control=instr[30] only for funct3=101, else 0 (ADDI never subtracts). funct3=001 requires instr[31:25]=0000000. funct3=101 requires 0000000 or 0100000. Otherwise illegal.
- LUI: a=0, b={instr[31:12],12'b0}, operation=000, control=0. AUIPC: same but a=pc.
- alu_lt/alu_ltu are computed from the final selected a/b and registered with the bundle.
- rd=instr[11:7] for legal instructions.
- Illegal: issued with illegal=1, a=b=0, operation=000, control=0, lt=ltu=0, rd=0 (no writeback).
- Reset asserted mid-stream: all entries lost immediately, no partial bundle emitted.

Decomposition:
- Shared package: opcode constants (OP, OP_IMM, LUI, AUIPC), funct3 encodings matching the ALU select (ADD=000, SLL=001, SLT=010, SLTU=011, XOR=100, SR=101, OR=110, AND=111), funct7 constants.
- One combinational sub-module, alu_issue_decode: instr/pc/rs1/rs2 → bundle including lt/ltu.
- Top level holds the handshake, skid register and flush logic.

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7 → next cycle out_valid=1, a=5, b=7, operation=000, control=0, rd=3, lt=1, ltu=1.
- SUB funct7=0100000 with rs1=0xFFFFFFFF, rs2=1 → control=1, lt=1, ltu=0. ADDI imm=0xFFF with rs1=0 → b=0xFFFFFFFF, control=0.
- SRAI imm[11:5]=0100000, shamt 4 → operation=101, control=1. SLLI with imm[11:5]=0100000 → illegal=1, rd=0, a=b=0.
- AUIPC with pc=0x1000, imm=0x12345 → a=0x1000, b=0x12345000. LUI → a=0. Unknown opcode 0x7F → illegal=1.
- Backpressure with SKID_BUFFER=1: 3 back-to-back inputs while out_ready=0 → first on output, second in skid, in_ready=0, third held upstream. Raise out_ready → order 1,2,3 preserved, no duplicates or drops.
- flush with out_valid=1, skid full and in_valid=1 → next cycle out_valid=0, in_ready=1, nothing emitted. rst_n pulsed low mid-stream → out_valid=0 asynchronously.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared encodings and the issued bundle type for the RV32I ALU decode/issue stage.
package alu_issue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  operation;
    logic        control;
    logic        lt;
    logic        ltu;
    logic [4:0]  rd;
    logic        illegal;
  } issue_bundle_t;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of one instruction into the ALU operand/control bundle.
module alu_issue_decode
  import alu_issue_pkg::*;
#(
  parameter bit ENABLE_UPPER = 1'b1
) (
  input  logic [31:0]   instr,
  input  logic [31:0]   pc,
  input  logic [31:0]   rs1_data,
  input  logic [31:0]   rs2_data,
  output issue_bundle_t bundle
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [2:0]  sel_op;
  logic        sel_ctl;
  logic        legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_op  = F3_ADD;
    sel_ctl = 1'b0;
    legal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        sel_a   = rs1_data;
        sel_b   = rs2_data;
        sel_op  = funct3;
        sel_ctl = instr[30];
        legal   = (funct7 == F7_BASE) ||
                  ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
      end
      OPC_OP_IMM: begin
        sel_a  = rs1_data;
        sel_b  = sext12(instr[31:20]);
        sel_op = funct3;
        case (funct3)
          F3_SLL: legal = (funct7 == F7_BASE);
          F3_SR: begin
            legal   = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            sel_ctl = instr[30];
          end
          // ADDI and the compares/logicals carry a full immediate; never subtract.
          default: legal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        sel_b = {instr[31:12], 12'b0};
        legal = ENABLE_UPPER;
      end
      OPC_AUIPC: begin
        sel_a = pc;
        sel_b = {instr[31:12], 12'b0};
        legal = ENABLE_UPPER;
      end
      default: legal = 1'b0;
    endcase

    // Illegal bundles are fully zeroed so execute never writes back or compares junk.
    if (!legal) begin
      sel_a   = '0;
      sel_b   = '0;
      sel_op  = F3_ADD;
      sel_ctl = 1'b0;
    end
  end

  always_comb begin
    bundle           = '0;
    bundle.a         = sel_a;
    bundle.b         = sel_b;
    bundle.operation = sel_op;
    bundle.control   = sel_ctl;
    bundle.lt        = ($signed(sel_a) < $signed(sel_b));
    bundle.ltu       = (sel_a < sel_b);
    bundle.rd        = legal ? instr[11:7] : 5'd0;
    bundle.illegal   = !legal;
  end

endmodule

// File: rtl/alu_issue.sv
// Decode-and-issue stage: registers the decoded bundle toward the ALU behind a valid/ready handshake.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter bit SKID_BUFFER  = 1'b1,
  parameter bit ENABLE_UPPER = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_operation,
  output logic        alu_control,
  output logic        alu_lt,
  output logic        alu_ltu,
  output logic [4:0]  rd,
  output logic        illegal
);

  // Handshake: a beat moves when valid && ready on a rising edge; a held output
  // (out_valid && !out_ready) keeps its bundle unchanged; flush wins over both transfers.

  issue_bundle_t dec;
  issue_bundle_t out_q;
  logic          out_valid_q;

  alu_issue_decode #(
    .ENABLE_UPPER(ENABLE_UPPER)
  ) u_decode (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .bundle   (dec)
  );

  generate
    if (SKID_BUFFER) begin : g_skid
      issue_bundle_t skid_q;
      logic          skid_valid_q;
      logic          in_xfer;

      assign in_ready = !skid_valid_q;
      assign in_xfer  = in_valid && in_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q  <= 1'b0;
          out_q        <= '0;
          skid_valid_q <= 1'b0;
          skid_q       <= '0;
        end else if (flush) begin
          out_valid_q  <= 1'b0;
          skid_valid_q <= 1'b0;
        end else if (!out_valid_q || out_ready) begin
          // Output slot frees this edge; the skid entry is older than any new input.
          if (skid_valid_q) begin
            out_q        <= skid_q;
            out_valid_q  <= 1'b1;
            skid_valid_q <= 1'b0;
          end else begin
            out_valid_q <= in_xfer;
            if (in_xfer) out_q <= dec;
          end
        end else if (in_xfer) begin
          skid_q       <= dec;
          skid_valid_q <= 1'b1;
        end
      end
    end else begin : g_pipe
      assign in_ready = !out_valid_q || out_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          out_q       <= '0;
        end else if (flush) begin
          out_valid_q <= 1'b0;
        end else if (in_ready) begin
          out_valid_q <= in_valid;
          if (in_valid) out_q <= dec;
        end
      end
    end
  endgenerate

  assign out_valid     = out_valid_q;
  assign alu_a         = out_q.a;
  assign alu_b         = out_q.b;
  assign alu_operation = out_q.operation;
  assign alu_control   = out_q.control;
  assign alu_lt        = out_q.lt;
  assign alu_ltu       = out_q.ltu;
  assign rd            = out_q.rd;
  assign illegal       = out_q.illegal;

endmodule
